// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns a single-port instruction memory, lets a loader
// fill it, then streams instructions out with stall, redirect and halt-on-zero support.
module fetch_sequencer #(
  parameter int AW           = 16,
  parameter bit HALT_ON_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  output logic          ld_ready,
  input  logic          ld_done,
  input  logic          stall,
  input  logic          br_valid,
  input  logic [31:0]   br_target,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          inst_valid,
  output logic [31:0]   inst_out,
  output logic [31:0]   inst_pc,
  output logic [1:0]    state_o,
  output logic [AW:0]   load_count
);

  // state | meaning
  // IDLE  | no memory traffic; waits for a loader word or start
  // LOAD  | loader words written at load_count until ld_done
  // FETCH | one read per unstalled cycle, data delivered next cycle
  // HALT  | stopped on a zero word; waits for start or a loader word
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FETCH = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n;
  logic [AW:0]   cnt, cnt_n;
  logic          rd_pending, rd_pending_n;
  logic [AW-1:0] rd_pc, rd_pc_n;
  logic          hold_valid, hold_valid_n;
  logic [31:0]   hold_data, hold_data_n;
  logic [AW-1:0] hold_pc, hold_pc_n;

  logic          wr, rd, ld_ready_c;
  logic [AW-1:0] wr_addr;
  logic          pres_valid;
  logic [31:0]   pres_data;
  logic [AW-1:0] pres_pc;
  logic          unused_br;

  assign unused_br = ^br_target[31:AW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      cnt        <= '0;
      rd_pending <= 1'b0;
      rd_pc      <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_pc    <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      cnt        <= cnt_n;
      rd_pending <= rd_pending_n;
      rd_pc      <= rd_pc_n;
      hold_valid <= hold_valid_n;
      hold_data  <= hold_data_n;
      hold_pc    <= hold_pc_n;
    end
  end

  // A read issued last cycle takes precedence; otherwise the stall hold register is shown.
  always_comb begin
    pres_valid = rd_pending | hold_valid;
    pres_data  = rd_pending ? mem_rdata : hold_data;
    pres_pc    = rd_pending ? rd_pc : hold_pc;
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    cnt_n        = cnt;
    rd_pending_n = 1'b0;
    rd_pc_n      = rd_pc;
    hold_valid_n = 1'b0;
    hold_data_n  = hold_data;
    hold_pc_n    = hold_pc;
    wr           = 1'b0;
    rd           = 1'b0;
    wr_addr      = '0;
    ld_ready_c   = 1'b0;

    case (state)
      S_IDLE, S_HALT: begin
        if (ld_valid) begin
          ld_ready_c = 1'b1;
          wr         = 1'b1;
          wr_addr    = '0;
          cnt_n      = (AW+1)'(1);
          state_n    = S_LOAD;
        end else if (start) begin
          pc_n    = '0;
          state_n = S_FETCH;
        end
      end
      S_LOAD: begin
        ld_ready_c = ~cnt[AW];
        if (ld_valid && !cnt[AW]) begin
          wr      = 1'b1;
          wr_addr = cnt[AW-1:0];
          cnt_n   = cnt + (AW+1)'(1);
        end
        if (ld_done) state_n = S_IDLE;
      end
      S_FETCH: begin
        if (stall) begin
          hold_valid_n = pres_valid;
          hold_data_n  = pres_data;
          hold_pc_n    = pres_pc;
        end else begin
          rd           = 1'b1;
          rd_pending_n = 1'b1;
          rd_pc_n      = pc;
          pc_n         = pc + AW'(1);
        end
        // An accepted zero word wins over a same-cycle redirect.
        if (HALT_ON_ZERO && pres_valid && !stall && (pres_data == 32'd0)) begin
          state_n      = S_HALT;
          rd_pending_n = 1'b0;
        end else if (br_valid) begin
          rd_pending_n = 1'b0;
          hold_valid_n = 1'b0;
          pc_n         = br_target[AW-1:0];
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign ld_ready   = ld_ready_c & ~rst;
  assign mem_en     = (wr | rd) & ~rst;
  assign mem_we     = wr & ~rst;
  assign mem_addr   = wr ? wr_addr : pc;
  assign mem_wdata  = ld_data;
  assign inst_valid = pres_valid;
  assign inst_out   = pres_data;
  assign inst_pc    = 32'(pres_pc);
  assign state_o    = state;
  assign load_count = cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer (AW=4): directed load/fetch scenarios plus randomized
// stall/redirect traffic checked against an instruction-stream reference model.
module tb_fetch_sequencer;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_ready;
  logic          ld_done;
  logic          stall;
  logic          br_valid;
  logic [31:0]   br_target;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          inst_valid;
  logic [31:0]   inst_out;
  logic [31:0]   inst_pc;
  logic [1:0]    state_o;
  logic [AW:0]   load_count;

  fetch_sequencer #(.AW(AW), .HALT_ON_ZERO(1'b1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .state_o    (state_o),
    .load_count (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory; read data is garbage unless a read was issued.
  logic [31:0] mem [DEPTH];
  int          wr_cnt [DEPTH];
  int          n_writes;
  always @(posedge clk) begin
    if (mem_en === 1'b1 && mem_we === 1'b1) begin
      mem[mem_addr]    <= mem_wdata;
      wr_cnt[mem_addr] <= wr_cnt[mem_addr] + 1;
      n_writes         <= n_writes + 1;
    end
    if (mem_en === 1'b1 && mem_we === 1'b0) mem_rdata <= mem[mem_addr];
    else                                    mem_rdata <= $urandom;
  end

  int          checks;
  int          errors;
  logic [31:0] img  [DEPTH];
  logic [31:0] wbuf [32];
  bit          fetch_on;
  bit          m_halted;
  bit          p_hold;
  int          mpc;
  int          n_acc;
  int          zpos;
  logic [31:0] p_pc;
  logic [31:0] p_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rnz();
    logic [31:0] v;
    v = $urandom;
    if (v == 32'd0) v = 32'h1;
    return v;
  endfunction

  // Stream model: accepted instructions must follow program order from img,
  // restarting at the target after a redirect and stopping after a zero word.
  task automatic model_check();
    if (m_halted) begin
      chk("halt_state", 64'(state_o), 64'd3);
      chk("halt_no_inst", 64'(inst_valid), 64'd0);
      chk("halt_no_mem", 64'(mem_en), 64'd0);
      fetch_on = 1'b0;
    end else begin
      chk("fetch_no_write", 64'(mem_we), 64'd0);
      if (p_hold) begin
        chk("stall_hold_valid", 64'(inst_valid), 64'd1);
        chk("stall_hold_pc", 64'(inst_pc), 64'(p_pc));
        chk("stall_hold_word", 64'(inst_out), 64'(p_out));
      end
      if (inst_valid === 1'b1 && stall === 1'b0) begin
        chk("stream_pc", 64'(inst_pc), 64'(32'(mpc)));
        chk("stream_word", 64'(inst_out), 64'(img[mpc]));
        n_acc++;
        if (img[mpc] == 32'd0) m_halted = 1'b1;
        else                   mpc = (mpc + 1) % DEPTH;
        if (br_valid && !m_halted) mpc = int'(br_target % 32'd16);
      end else if (br_valid) begin
        mpc = int'(br_target % 32'd16);
      end
      p_hold = (inst_valid === 1'b1) && stall && !br_valid;
      p_pc   = inst_pc;
      p_out  = inst_out;
    end
  endtask

  task automatic step(input logic st, input logic sv, input logic bv, input logic [31:0] bt);
    @(negedge clk);
    start     = st;
    stall     = sv;
    br_valid  = bv;
    br_target = bt;
    ld_valid  = 1'b0;
    ld_done   = 1'b0;
    #1;
    if (fetch_on) model_check();
  endtask

  task automatic arm_model();
    fetch_on = 1'b1;
    m_halted = 1'b0;
    p_hold   = 1'b0;
    mpc      = 0;
    n_acc    = 0;
  endtask

  // Offers wbuf[0..n-1]; ld_done either rides with the last word or follows it.
  task automatic load_prog(input int n, input bit done_on_last);
    int base_tot;
    int base_cnt [DEPTH];
    int exp_n;
    base_tot = n_writes;
    for (int i = 0; i < DEPTH; i++) base_cnt[i] = wr_cnt[i];
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start    = 1'b0;
      stall    = 1'b0;
      br_valid = 1'b0;
      ld_valid = 1'b1;
      ld_data  = wbuf[i];
      ld_done  = done_on_last && (i == n - 1);
      #1;
      chk("ld_ready_offer", 64'(ld_ready), 64'(i < DEPTH));
      if (i < DEPTH) img[i] = wbuf[i];
    end
    if (!done_on_last) begin
      @(negedge clk);
      ld_valid = 1'b0;
      ld_done  = 1'b1;
      #1;
      chk("ld_ready_done", 64'(ld_ready), 64'(n < DEPTH));
    end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_done  = 1'b0;
    #1;
    exp_n = (n < DEPTH) ? n : DEPTH;
    chk("ld_state_idle", 64'(state_o), 64'd0);
    chk("ld_count", 64'(load_count), 64'(exp_n));
    chk("ld_total_writes", 64'(n_writes - base_tot), 64'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      chk("ld_written_once", 64'(wr_cnt[i] - base_cnt[i]), 64'd1);
      chk("ld_word", 64'(mem[i]), 64'(img[i]));
    end
  endtask

  initial begin
    int base_tot;
    logic sv, bv;
    int   k;
    checks   = 0;
    errors   = 0;
    fetch_on = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    ld_valid  = 1'b0;
    ld_data   = '0;
    ld_done   = 1'b0;
    stall     = 1'b0;
    br_valid  = 1'b0;
    br_target = '0;

    @(negedge clk);
    #1;
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst_out", 64'(inst_out), 64'd0);
    chk("rst_inst_pc", 64'(inst_pc), 64'd0);
    chk("rst_load_count", 64'(load_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Eleven-word load
    for (int i = 0; i < 11; i++) wbuf[i] = rnz();
    load_prog(11, 1'b0);

    // Oversized load: only the first 16 words may be written
    for (int i = 0; i < 20; i++) wbuf[i] = rnz();
    load_prog(20, 1'b0);

    // 0x11, 0x22, 0x00 then fetch to halt; last word arrives with ld_done
    wbuf[0] = 32'h11;
    wbuf[1] = 32'h22;
    wbuf[2] = 32'h0;
    load_prog(3, 1'b1);
    arm_model();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("start_cycle_idle", 64'(state_o), 64'd0);
    chk("start_cycle_no_mem", 64'(mem_en), 64'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("first_read_state", 64'(state_o), 64'd2);
    chk("first_read_en", 64'(mem_en), 64'd1);
    chk("first_read_addr", 64'(mem_addr), 64'd0);
    chk("first_read_no_inst", 64'(inst_valid), 64'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("p0_word", 64'(inst_out), 64'h11);
    chk("p0_pc", 64'(inst_pc), 64'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("p1_word", 64'(inst_out), 64'h22);
    chk("p1_pc", 64'(inst_pc), 64'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("p2_zero_valid", 64'(inst_valid), 64'd1);
    chk("p2_zero_word", 64'(inst_out), 64'd0);
    chk("p2_zero_pc", 64'(inst_pc), 64'd2);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("halt_entered", 64'(state_o), 64'd3);

    // Reload from HALT, then stall and redirect directed steps
    for (int i = 0; i < 12; i++) wbuf[i] = rnz();
    load_prog(12, 1'b0);
    arm_model();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("pre_stall_pc0", 64'(inst_pc), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0);
      chk("stall_pc1", 64'(inst_pc), 64'd1);
      chk("stall_word1", 64'(inst_out), 64'(img[1]));
      chk("stall_no_read", 64'(mem_en), 64'd0);
    end
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("after_stall_pc2", 64'(inst_pc), 64'd2);
    chk("after_stall_word2", 64'(inst_out), 64'(img[2]));
    step(1'b0, 1'b0, 1'b1, 32'd8);
    chk("br_at_pc3", 64'(inst_pc), 64'd3);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("br_squash", 64'(inst_valid), 64'd0);
    chk("br_read_addr", 64'(mem_addr), 64'd8);
    chk("br_read_en", 64'(mem_en), 64'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("br_target_pc", 64'(inst_pc), 64'd8);
    chk("br_target_word", 64'(inst_out), 64'(img[8]));

    // Randomized stall/redirect traffic over a zero-free image (pc wraps at 16)
    for (int c = 0; c < 300; c++) begin
      sv = ($urandom_range(0, 9) < 3);
      bv = ($urandom_range(0, 15) == 0);
      step(1'b0, sv, bv, $urandom);
    end
    chk("stream_progress", 64'(n_acc >= 100), 64'd1);

    // Reset in the middle of fetch
    fetch_on = 1'b0;
    @(negedge clk);
    stall    = 1'b0;
    br_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("fetch_rst_state", 64'(state_o), 64'd0);
    chk("fetch_rst_mem_en", 64'(mem_en), 64'd0);
    chk("fetch_rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("fetch_rst_inst_out", 64'(inst_out), 64'd0);
    chk("fetch_rst_inst_pc", 64'(inst_pc), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset after four loader writes: no fifth write
    base_tot = n_writes;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = rnz();
      if (i < 4) img[i] = ld_data;
    end
    #1;
    rst = 1'b1;
    #1;
    chk("load_rst_ld_ready", 64'(ld_ready), 64'd0);
    chk("load_rst_mem_en", 64'(mem_en), 64'd0);
    chk("load_rst_mem_we", 64'(mem_we), 64'd0);
    chk("load_rst_state", 64'(state_o), 64'd0);
    chk("load_rst_count", 64'(load_count), 64'd0);
    @(negedge clk);
    ld_valid = 1'b0;
    chk("load_rst_writes", 64'(n_writes - base_tot), 64'd4);
    rst = 1'b0;
    #1;
    chk("load_rst_after_count", 64'(load_count), 64'd0);
    chk("load_rst_after_state", 64'(state_o), 64'd0);

    // Zero word at a random position: stream must stop right after it
    zpos = $urandom_range(1, 14);
    for (int i = 0; i < DEPTH; i++) wbuf[i] = (i == zpos) ? 32'd0 : rnz();
    load_prog(DEPTH, 1'b1);
    arm_model();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    k = 0;
    while (!m_halted && k < 200) begin
      step(1'b0, ($urandom_range(0, 3) == 0), 1'b0, 32'd0);
      k++;
    end
    chk("zero_halt_reached", 64'(m_halted), 64'd1);
    chk("zero_halt_count", 64'(n_acc), 64'(zpos + 1));
    step(1'b0, 1'b0, 1'b0, 32'd0);

    // Restart from HALT at pc 0
    arm_model();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("restart_from_halt", 64'(state_o), 64'd3);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("restart_valid", 64'(inst_valid), 64'd1);
    chk("restart_pc0", 64'(inst_pc), 64'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter AW, default 16, instruction-memory word-address width (memory depth 2^AW words).
REQ-002 Parameter HALT_ON_ZERO, default 1, when 1 a fetched all-zero word stops fetch.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  one-cycle pulse: begin fetching at PC 0 from IDLE or HALT.
REQ-006 ld_valid / ld_data  input  1 / 32  loader word offered for write.
REQ-007 ld_ready  output  1  loader word accepted this cycle when ld_valid && ld_ready.
REQ-008 ld_done  input  1  loader finished; one-cycle pulse.
REQ-009 stall  input  1  downstream cannot accept an instruction this cycle.
REQ-010 br_valid / br_target  input  1 / 32  redirect fetch to br_target[AW-1:0].
REQ-011 mem_en / mem_we / mem_addr / mem_wdata  output  1/1/AW/32  single-port memory request.
REQ-012 mem_rdata  input  32  memory read data, valid exactly one cycle after a read request (mem_en && !mem_we).
REQ-013 inst_valid / inst_out / inst_pc  output  1/32/32  delivered instruction and its address.
REQ-014 state_o  output  2  IDLE=0, LOAD=1, FETCH=2, HALT=3.
REQ-015 load_count  output  AW+1  words written by the current/last load.

Function
REQ-016 The block SHALL own the memory port; only one of loader write or fetch read is issued per cycle.
REQ-017 IDLE: ld_valid moves to LOAD (same-cycle write accepted); start moves to FETCH; ld_valid wins if both asserted.
REQ-018 LOAD: ld_ready=1; each accepted word writes mem_addr=load_count, mem_we=1, mem_en=1, then load_count increments.
REQ-019 LOAD: at load_count=2^AW ld_ready SHALL drop to 0 and further words are refused, not wrapped.
REQ-020 LOAD: ld_done returns to IDLE next cycle; a word accepted in the ld_done cycle is still written.
REQ-021 Entry to LOAD from IDLE/HALT SHALL clear load_count to 0; fetch is never issued in LOAD.
REQ-022 FETCH: each cycle with !stall a read is issued at pc (mem_addr=pc[AW-1:0]) and pc increments modulo 2^AW.
REQ-023 Latency: an instruction read in cycle N appears on inst_out with inst_valid=1 and inst_pc=its address in cycle N+1.
REQ-024 stall=1: no read issued, pc held; inst_valid/inst_out/inst_pc held unchanged (a one-entry hold register captures mem_rdata arriving during stall).
REQ-025 br_valid in FETCH: the read issued that cycle and any held instruction are squashed (inst_valid=0 next cycle); next read issues at br_target; br_valid beats stall for the redirect but no read issues while stall=1.
REQ-026 HALT_ON_ZERO=1: a delivered word equal to 0 SHALL be presented with inst_valid=1, then the FSM enters HALT and the speculatively issued next read is discarded.
REQ-027 HALT: no memory activity, inst_valid=0; start re-enters FETCH at pc=0; ld_valid enters LOAD.
REQ-028 start or ld_valid while in LOAD or FETCH SHALL be ignored.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, pc=0, load_count=0, mem_en=0, mem_we=0, ld_ready=0, inst_valid=0, inst_out=0, inst_pc=0.
REQ-030 Reset mid-load or mid-fetch SHALL abort without a further memory write; the first rising edge after rst falls operates from IDLE.

Verification
REQ-031 Load 11 words (ld_valid held 11 cycles) then ld_done -> addresses 0..10 written once each, load_count=11, state IDLE.
REQ-032 start after load of words 0x11,0x22,0x00 -> inst_out 0x11@pc0, 0x22@pc1, 0x00@pc2 on consecutive cycles starting one cycle after first read, then state HALT.
REQ-033 stall asserted 3 cycles while inst_pc=1 -> inst_out/inst_pc stay at word 1 for those cycles; pc 2 delivered in the cycle after stall drops, no word lost or duplicated.
REQ-034 br_valid with br_target=8 while inst_pc=3 -> next cycle inst_valid=0, following cycle inst_pc=8.
REQ-035 rst pulsed during LOAD after 4 writes -> outputs at reset values immediately, no fifth write, load_count=0.
REQ-036 AW=4, loader offers 20 words -> exactly 16 writes, ld_ready=0 from the 17th offer until ld_done.
